// File: rtl/count4_seq_monitor.sv
// Health monitor for the 4-bit up/down counter: verifies each Y step is +1/-1 (mod 16)
// as selected by the previously sampled CTL, and reports wraps, direction changes and errors.
module count4_seq_monitor #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [3:0]       y_in,
  input  logic             ctl_in,
  output logic             wrap,
  output logic             dir_chg,
  output logic             err,
  output logic             err_sticky,
  output logic [CNT_W-1:0] wrap_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             checking
);

  typedef enum logic [1:0] {IDLE, PRIME, CHECK} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t     state;
  logic [3:0] prev_y;
  logic       prev_ctl;

  logic [3:0] exp_y;
  logic       live;
  logic       step_err;
  logic       step_wrap;
  logic       step_dir;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    exp_y     = prev_ctl ? (prev_y - 4'd1) : (prev_y + 4'd1);
    live      = (state == CHECK) && en;
    step_err  = 1'b0;
    step_wrap = 1'b0;
    step_dir  = 1'b0;
    if (live) begin
      step_err  = (y_in != exp_y);
      // A wrap is only reported on a step that is also legal.
      step_wrap = (y_in == exp_y) &&
                  ((!prev_ctl && prev_y == 4'hF) || (prev_ctl && prev_y == 4'h0));
      step_dir  = (ctl_in != prev_ctl);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      prev_y     <= 4'd0;
      prev_ctl   <= 1'b0;
      wrap       <= 1'b0;
      dir_chg    <= 1'b0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
      wrap_cnt   <= '0;
      err_cnt    <= '0;
    end else begin
      wrap    <= step_wrap;
      dir_chg <= step_dir;
      err     <= step_err;

      case (state)
        IDLE: begin
          if (en) state <= PRIME;
        end
        PRIME: begin
          prev_y   <= y_in;
          prev_ctl <= ctl_in;
          state    <= en ? CHECK : IDLE;
        end
        CHECK: begin
          if (en) begin
            // Always resynchronise to the actual value so one glitch costs at most two errors.
            prev_y   <= y_in;
            prev_ctl <= ctl_in;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (clr) begin
        wrap_cnt   <= '0;
        err_cnt    <= '0;
        err_sticky <= 1'b0;
      end else begin
        if (step_wrap && wrap_cnt != '1) wrap_cnt <= wrap_cnt + CNT_ONE;
        if (step_err && err_cnt != '1)   err_cnt  <= err_cnt + CNT_ONE;
        if (step_err)                    err_sticky <= 1'b1;
      end
    end
  end

  assign checking = (state == CHECK);

endmodule

// File: tb/tb_count4_seq_monitor.sv
// Directed bench for count4_seq_monitor: reset/prime, wraps, direction change,
// glitch resync, saturation with clr, mid-check reset and enable drop.
module tb_count4_seq_monitor;

  localparam int CNT_W = 8;

  logic             clock = 1'b0;
  logic             reset;
  logic             en;
  logic             clr;
  logic [3:0]       y_in;
  logic             ctl_in;
  logic             wrap;
  logic             dir_chg;
  logic             err;
  logic             err_sticky;
  logic [CNT_W-1:0] wrap_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic             checking;

  int n_tests = 0;
  int n_fail  = 0;

  count4_seq_monitor #(.CNT_W(CNT_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .en         (en),
    .clr        (clr),
    .y_in       (y_in),
    .ctl_in     (ctl_in),
    .wrap       (wrap),
    .dir_chg    (dir_chg),
    .err        (err),
    .err_sticky (err_sticky),
    .wrap_cnt   (wrap_cnt),
    .err_cnt    (err_cnt),
    .checking   (checking)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one Y/CTL sample on the falling edge, then sample outputs just after the rising edge.
  task automatic tick(input logic [3:0] y, input logic c);
    @(negedge clock);
    y_in   = y;
    ctl_in = c;
    @(posedge clock);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_wrap"}, 32'(wrap), 0);
    check({tag, "_dir"},  32'(dir_chg), 0);
    check({tag, "_err"},  32'(err), 0);
  endtask

  logic [3:0] yv;

  initial begin
    reset = 1'b0; en = 1'b0; clr = 1'b0; y_in = 4'd0; ctl_in = 1'b0;

    // Reset held for two edges: everything stays zero.
    for (int i = 0; i < 2; i++) begin
      tick(4'd0, 1'b0);
      check_quiet("rst");
      check("rst_checking", 32'(checking), 0);
      check("rst_sticky", 32'(err_sticky), 0);
      check("rst_wrap_cnt", 32'(wrap_cnt), 0);
      check("rst_err_cnt", 32'(err_cnt), 0);
    end

    // Release with en=1 and counter running up from 0.
    reset = 1'b1; en = 1'b1;
    tick(4'd0, 1'b0);
    check("prime_checking0", 32'(checking), 0);
    tick(4'd1, 1'b0);
    check("prime_checking1", 32'(checking), 1);
    for (int i = 2; i < 20; i++) begin
      yv = 4'(i);
      tick(yv, 1'b0);
      check("run_err", 32'(err), 0);
      check("run_wrap", 32'(wrap), (i == 16) ? 1 : 0);
    end
    check("run_err_cnt", 32'(err_cnt), 0);
    check("run_wrap_cnt", 32'(wrap_cnt), 1);

    // clr while running clears the counters but not the state.
    clr = 1'b1;
    tick(4'd4, 1'b0);
    clr = 1'b0;
    check("clr_wrap_cnt", 32'(wrap_cnt), 0);
    check("clr_checking", 32'(checking), 1);

    // 32 up steps: two 15->0 wraps.
    for (int j = 0; j < 32; j++) begin
      yv = 4'(5 + j);
      tick(yv, 1'b0);
      check("up_wrap", 32'(wrap), (yv == 4'd0) ? 1 : 0);
      check("up_err", 32'(err), 0);
    end
    check("up_wrap_cnt", 32'(wrap_cnt), 2);

    // Direction change at 9: 8,9,10,9,8 ... then down through 0->15.
    for (int j = 5; j < 10; j++) begin
      yv = 4'(j);
      tick(yv, 1'b0);
      check("dir_pre_dir", 32'(dir_chg), 0);
      check("dir_pre_err", 32'(err), 0);
    end
    tick(4'd10, 1'b1);
    check("dir_pulse", 32'(dir_chg), 1);
    check("dir_err", 32'(err), 0);
    check("dir_wrap", 32'(wrap), 0);
    for (int k = 0; k < 12; k++) begin
      yv = 4'(9 - k);
      tick(yv, 1'b1);
      check("down_dir", 32'(dir_chg), 0);
      check("down_err", 32'(err), 0);
      check("down_wrap", 32'(wrap), (yv == 4'd15) ? 1 : 0);
    end
    check("down_wrap_cnt", 32'(wrap_cnt), 3);

    // Reset for one edge mid-check.
    reset = 1'b0;
    tick(4'd13, 1'b1);
    check("mid_rst_checking", 32'(checking), 0);
    check("mid_rst_wrap_cnt", 32'(wrap_cnt), 0);
    check_quiet("mid_rst");
    reset = 1'b1;
    tick(4'd2, 1'b0);
    check("reprime_checking0", 32'(checking), 0);
    tick(4'd3, 1'b0);
    check("reprime_checking1", 32'(checking), 1);
    tick(4'd4, 1'b0);
    check("reprime_err", 32'(err), 0);

    // Glitch 3,4,12,6,7: errors into and out of the glitch only.
    tick(4'd12, 1'b0);
    check("glitch_in_err", 32'(err), 1);
    check("glitch_in_wrap", 32'(wrap), 0);
    tick(4'd6, 1'b0);
    check("glitch_out_err", 32'(err), 1);
    tick(4'd7, 1'b0);
    check("glitch_resync_err", 32'(err), 0);
    check("glitch_err_cnt", 32'(err_cnt), 2);
    check("glitch_sticky", 32'(err_sticky), 1);
    tick(4'd8, 1'b0);
    check("glitch_after_err", 32'(err), 0);
    check("glitch_after_sticky", 32'(err_sticky), 1);

    // Held counter: error every cycle, err_cnt saturates at 255.
    for (int i = 0; i < 300; i++) begin
      tick(4'd5, 1'b0);
      check("hold_err", 32'(err), 1);
      if (i == 10) check("hold_err_cnt_mid", 32'(err_cnt), 13);
    end
    check("sat_err_cnt", 32'(err_cnt), 255);
    check("sat_sticky", 32'(err_sticky), 1);

    // clr wins over the same-cycle increment; the pulse still fires.
    clr = 1'b1;
    tick(4'd5, 1'b0);
    clr = 1'b0;
    check("sat_clr_err", 32'(err), 1);
    check("sat_clr_err_cnt", 32'(err_cnt), 0);
    check("sat_clr_sticky", 32'(err_sticky), 0);
    tick(4'd5, 1'b0);
    check("resume_err", 32'(err), 1);
    check("resume_err_cnt", 32'(err_cnt), 1);
    check("resume_sticky", 32'(err_sticky), 1);

    // Dropping en leaves CHECK without checking that edge.
    en = 1'b0;
    tick(4'd5, 1'b0);
    check("en_off_checking", 32'(checking), 0);
    check("en_off_err", 32'(err), 0);
    check("en_off_err_cnt", 32'(err_cnt), 1);
    en = 1'b1;
    tick(4'd6, 1'b0);
    check("en_on_checking0", 32'(checking), 0);
    tick(4'd7, 1'b0);
    check("en_on_checking1", 32'(checking), 1);
    tick(4'd8, 1'b0);
    check("en_on_err", 32'(err), 0);
    check("en_on_err_cnt", 32'(err_cnt), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/count4_seq_monitor.md
Name: count4_seq_monitor

Overview:
- Downstream checking stage for the 4-bit up/down counter.
- Samples the counter output Y and its direction control CTL every clock and verifies that each step is exactly +1 or -1 (mod 16), as selected by the previous CTL.
- Reports wrap-arounds, direction changes and sequence errors as single-cycle pulses, plus saturating event counts and a sticky error flag.
- Used in-system as a health monitor and on benches as a self-checking scoreboard for the counter.

Parameters:
- CNT_W, 8, width of the wrap and error event counters (both saturate at 2**CNT_W-1).

Ports:
- clock  input  1  single system clock; all logic on posedge.
- reset  input  1  synchronous, active-low reset.
- en  input  1  monitor enable; 0 forces IDLE.
- clr  input  1  synchronous clear of counters and sticky flag.
- y_in  input  4  counter output Y.
- ctl_in  input  1  counter direction control CTL (0 = up, 1 = down).
- wrap  output  1  one-cycle pulse on a legal 15->0 (up) or 0->15 (down) step.
- dir_chg  output  1  one-cycle pulse when ctl_in differs from the previously sampled CTL.
- err  output  1  one-cycle pulse on an illegal step.
- err_sticky  output  1  set on any err; cleared only by reset or clr.
- wrap_cnt  output  CNT_W  saturating count of wrap pulses.
- err_cnt  output  CNT_W  saturating count of err pulses.
- checking  output  1  1 while in the CHECK state.

Behaviour:
- Reset: all logic is reset synchronously when reset=0 at a posedge clock.
  - All outputs go to 0; state = IDLE; prev_y = 0; prev_ctl = 0.
  - Reset has priority over en and clr.
- State machine: IDLE, PRIME, CHECK.
  - IDLE: no checks; wrap, dir_chg and err held at 0. If en=1, go to PRIME.
  - PRIME: capture prev_y <= y_in and prev_ctl <= ctl_in; no checks. Next state is CHECK if en=1, else IDLE.
  - CHECK: every cycle, compare y_in against the expected value, then update prev_y <= y_in and prev_ctl <= ctl_in. If en=0, go to IDLE on the next edge; no check is made on that edge.
- Expected value: prev_y + 1 if prev_ctl=0, else prev_y - 1, computed mod 16 (4-bit wrap).
- Outputs are registered: pulses assert in the cycle after the posedge that sampled the offending or qualifying y_in. Latency is 1 clock.
- err: asserted when y_in != expected.
  - Resynchronisation: prev_y always takes the actual y_in, so a single glitch produces at most two err pulses (into the glitch and out of it).
  - A held counter (y_in == prev_y) flags err every cycle.
- wrap: asserted only on a legal step where prev_y=15, prev_ctl=0, y_in=0, or prev_y=0, prev_ctl=1, y_in=15. An illegal step never asserts wrap.
- dir_chg: asserted in CHECK when ctl_in != prev_ctl. It is independent of err and wrap; any combination may be asserted together.
- Counters:
  - wrap_cnt and err_cnt increment on their pulse and hold at all-ones; they never roll over.
  - err_sticky sets together with the first err pulse.
- clr=1 at a posedge:
  - wrap_cnt, err_cnt and err_sticky go to 0. clr wins over a same-cycle increment or set.
  - The wrap, dir_chg and err pulses for that cycle still assert.
  - State, prev_y and prev_ctl are unaffected.
- Reset mid-operation returns to IDLE. After reset is released, the first check happens two edges after en is seen high (IDLE->PRIME, PRIME->CHECK).
- checking = 1 exactly when state = CHECK.

Test Plan:
- Reset and prime: hold reset=0 for 2 cycles, then reset=1 with en=1, CTL=0, counter running from 0.
  - All outputs stay 0 through reset.
  - checking=1 from the second edge after release.
  - err_cnt stays 0 over 20 cycles.
- Up wrap: en=1, CTL=0, counter free-running for 32 steps from 0.
  - wrap pulses exactly 2 times, each in the cycle after y_in=0 is sampled following 15.
  - wrap_cnt=2, err=0 throughout.
- Direction change at 9: CTL goes 0->1 after Y reaches 9 (sequence 8,9,10,9,8).
  - dir_chg pulses once, err=0.
  - Then run down through 0->15: wrap pulses once and wrap_cnt increments by 1.
- Glitch injection: force y_in to the sequence 3,4,12,6,7 with CTL=0.
  - err pulses twice, on 12 and on 6.
  - err_cnt=2, err_sticky=1 and stays 1 afterwards.
  - The step 6->7 gives no err.
- Saturation and clr, with CNT_W=8: hold y_in=5 constant for 300 cycles in CHECK.
  - err_cnt saturates at 255.
  - Asserting clr for one cycle gives err_cnt=0 and err_sticky=0 on the next cycle, while err continues pulsing and err_cnt resumes from 1.
- Reset mid-check: drive reset=0 for one edge while in CHECK with wrap_cnt=3.
  - Next cycle: state IDLE, wrap_cnt=0, checking=0.
  - Normal checking resumes after re-priming.
